enemy_rom_arbiter: RTL and testbench
====================================

Name: enemy_rom_arbiter

Overview:
- Parametrised successor to the enemy sprite-ROM address mux.
- Arbitrates N_CH enemy renderers onto one shared sprite ROM read port, one access per cycle, using a req/gnt handshake with round-robin fairness.
- Tracks in-flight reads and routes each returned pixel word back to the channel that issued it, with a one-hot valid strobe.
- Sits between the enemy render units and the single-port sprite altsyncram.

Parameters:
- N_CH, 8, number of requesting channels (2..16).
- ADDR_W, 12, sprite ROM address width per channel.
- DATA_W, 8, ROM word width.
- ROM_LAT, 2, ROM read latency in cycles from rom_rden-high cycle to valid rom_q (1..4).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- req  in  N_CH  per-channel read request, held until granted.
- addr_in  in  N_CH*ADDR_W  packed addresses; channel k at bits [k*ADDR_W +: ADDR_W].
- gnt  out  N_CH  combinational one-hot grant; zero when req==0.
- rom_addr  out  ADDR_W  registered ROM address.
- rom_rden  out  1  registered ROM read enable.
- rom_q  in  DATA_W  ROM read data.
- rdata  out  DATA_W  returned word, registered.
- rvalid  out  N_CH  one-hot, one-cycle strobe marking the owner of rdata.

Behaviour:
- Reset (async assert, sync release):
  - rom_addr=0, rom_rden=0, rdata=0, rvalid=0.
  - Round-robin pointer ptr=0; in-flight tag pipeline cleared.
- Grant:
  - gnt selects the first asserted req scanning from index ptr upward, wrapping modulo N_CH. At most one bit is set.
  - Accept occurs at a rising edge where req[k]&gnt[k]. The requester must drop or change req/addr in the following cycle; holding req high means a new request.
- On accept of channel k at edge E0:
  - rom_addr <= addr_in[k], rom_rden <= 1.
  - ptr <= (k+1) mod N_CH.
  - Tag {valid=1, idx=k} enters a ROM_LAT-deep shift register.
- No accept at an edge:
  - rom_rden <= 0.
  - rom_addr holds its previous value.
  - ptr holds.
  - A tag with valid=0 is shifted in.
- Return:
  - When a valid tag exits the shift register at edge E0+ROM_LAT, capture rdata <= rom_q and rvalid <= one-hot(idx).
  - rvalid is high exactly in the cycle after edge E0+ROM_LAT, i.e. latency ROM_LAT+1 edges from accept.
  - Otherwise rvalid <= 0 and rdata holds.
- Throughput: one accept per cycle sustained. Returns keep issue order. No back-pressure on the return side.
- Fairness: with all req bits held high, grants cycle 0,1,...,N_CH-1,0. No channel waits more than N_CH-1 accepts.
- Boundaries:
  - A single requester gets a grant every cycle.
  - ptr wraps from N_CH-1 to 0.
  - A request and a return in the same cycle are independent.
  - Reset mid-operation discards in-flight reads: no rvalid is produced for them after release.
- Width rules: ptr and idx are clog2(N_CH) bits. With N_CH not a power of 2, wrap is explicit at N_CH-1.

Optional Feature:
- Macro: ENEMY_ARB_FIXED_PRIO_EN.
- Defined: round-robin is replaced by fixed priority, lowest index wins. ptr logic is removed, and gnt = lowest set bit of req. Handshake, latency and tag routing are unchanged.
- Undefined: round-robin as specified above.

Test Plan:
- Reset then idle, req=0 -> gnt=0, rom_rden=0, rvalid=0, rom_addr=0 for 20 cycles.
- Single request, N_CH=8, ROM_LAT=2: req[3]=1 for one cycle with addr 0x2A5, ROM model returns addr[7:0] -> rom_addr=0x2A5 with rom_rden=1 one cycle after accept; rvalid=8'b00001000 and rdata=0xA5 exactly 3 edges after accept, for one cycle.
- Round-robin: all 8 req held high for 16 cycles -> gnt sequence 0..7,0..7. The rvalid sequence is the same order, delayed 3 cycles, with rdata matching each channel's address.
- Contention after wrap: ptr=7 and req=8'b10000001 -> grant 7, then grant 0. Under ENEMY_ARB_FIXED_PRIO_EN -> grant 0 first, then 7.
- Reset mid-flight: accept ch2 and ch5 on consecutive edges, assert rst one cycle later for 2 cycles -> no rvalid afterwards, ptr=0. The next request from ch4 is granted normally.
- Parameter sweep N_CH=5, ROM_LAT=1 and 4: all req high -> grant order 0..4 wrapping, return latency 2 and 5 edges respectively.

Source files
------------

// File: rtl/enemy_rom_arbiter.sv
// enemy_rom_arbiter
//   Shares one sprite ROM read port among N_CH enemy render units. Each cycle
//   at most one requester is granted. The granted address goes to the ROM,
//   and a tag of the form {valid, channel} travels alongside the ROM latency.
//   When the tag comes out, the returned word is steered back to its owner
//   with a one-cycle, one-hot rvalid strobe.
//
//   Build option:
//     ENEMY_ARB_FIXED_PRIO_EN  When defined, the lowest asserted request wins
//                              and there is no round-robin pointer. When it is
//                              undefined (the default), arbitration is
//                              round-robin.
//
//   Ports:
//     clk       system clock
//     rst       asynchronous active-high reset
//     req       per-channel read request, held until granted
//     addr_in   packed channel addresses, channel k at [k*ADDR_W +: ADDR_W]
//     gnt       combinational one-hot grant, zero when no request is present
//     rom_addr  registered ROM address
//     rom_rden  registered ROM read enable
//     rom_q     ROM read data; must be valid ROM_LAT edges after the accept
//     rdata     returned word, held until the next return
//     rvalid    one-hot strobe that marks the owner of rdata
module enemy_rom_arbiter #(
    parameter int N_CH    = 8,
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 8,
    parameter int ROM_LAT = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_CH-1:0]        req,
    input  logic [N_CH*ADDR_W-1:0] addr_in,
    output logic [N_CH-1:0]        gnt,
    output logic [ADDR_W-1:0]      rom_addr,
    output logic                   rom_rden,
    input  logic [DATA_W-1:0]      rom_q,
    output logic [DATA_W-1:0]      rdata,
    output logic [N_CH-1:0]        rvalid
);

    localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [IDX_W-1:0]   gnt_idx;
    logic               gnt_any;
    logic [ADDR_W-1:0]  sel_addr;
    logic [ROM_LAT-1:0] tag_vld;
    logic [IDX_W-1:0]   tag_idx [ROM_LAT];

`ifdef ENEMY_ARB_FIXED_PRIO_EN
    // The scan runs downward, so the lowest set bit is the last one written.
    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (req[i]) begin
                gnt_idx = IDX_W'(i);
                gnt_any = 1'b1;
            end
        end
    end
`else
    localparam logic [IDX_W:0]   N_CH_X = (IDX_W + 1)'(N_CH);
    localparam logic [IDX_W-1:0] LAST   = IDX_W'(N_CH - 1);

    logic [IDX_W-1:0] ptr;
    logic [IDX_W:0]   cand;

    // Scan from ptr upward. The wrap is explicit, so a non-power-of-2 N_CH
    // never produces an index at or beyond N_CH.
    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        cand    = '0;
        for (int i = 0; i < N_CH; i++) begin
            cand = {1'b0, ptr} + (IDX_W + 1)'(i);
            if (cand >= N_CH_X) begin
                cand = cand - N_CH_X;
            end
            if (!gnt_any && req[cand[IDX_W-1:0]]) begin
                gnt_idx = cand[IDX_W-1:0];
                gnt_any = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (gnt_any) begin
            ptr <= (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;
        end
    end
`endif

    always_comb begin
        gnt = '0;
        if (gnt_any) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        sel_addr = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (gnt_idx == IDX_W'(i)) begin
                sel_addr = addr_in[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // gnt is a subset of req, so any grant is an accept at this edge.
    // Stage 0 of the tag pipe is loaded at the accept edge. The last stage
    // is therefore presented ROM_LAT-1 edges later and consumed on edge
    // accept+ROM_LAT, which is when rom_q holds this read's data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_addr <= '0;
            rom_rden <= 1'b0;
            rdata    <= '0;
            rvalid   <= '0;
            tag_vld  <= '0;
            for (int i = 0; i < ROM_LAT; i++) begin
                tag_idx[i] <= '0;
            end
        end else begin
            rom_rden <= gnt_any;
            if (gnt_any) begin
                rom_addr <= sel_addr;
            end
            tag_vld[0] <= gnt_any;
            tag_idx[0] <= gnt_idx;
            for (int i = 1; i < ROM_LAT; i++) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_idx[i] <= tag_idx[i-1];
            end
            if (tag_vld[ROM_LAT-1]) begin
                rdata  <= rom_q;
                rvalid <= N_CH'(1) << tag_idx[ROM_LAT-1];
            end else begin
                rvalid <= '0;
            end
        end
    end

endmodule

// File: tb/tb_enemy_rom_arbiter.sv
// Directed bench for enemy_rom_arbiter. It drives three instances:
//   a: N_CH=8, ROM_LAT=2
//   b: N_CH=5, ROM_LAT=1
//   c: N_CH=5, ROM_LAT=4
// Each instance is paired with a ROM model that returns addr[7:0].
// Inputs change and outputs are sampled on the falling edge.
module tb_enemy_rom_arbiter;

    logic        clk;
    logic        rst;

    logic [7:0]  req_a;
    logic [95:0] addr_a;
    logic [7:0]  gnt_a;
    logic [11:0] rom_addr_a;
    logic        rom_rden_a;
    logic [7:0]  rom_q_a;
    logic [7:0]  rdata_a;
    logic [7:0]  rvalid_a;

    logic [4:0]  req_b;
    logic [59:0] addr_b;
    logic [4:0]  gnt_b;
    logic [11:0] rom_addr_b;
    logic        rom_rden_b;
    logic [7:0]  rom_q_b;
    logic [7:0]  rdata_b;
    logic [4:0]  rvalid_b;

    logic [4:0]  req_c;
    logic [59:0] addr_c;
    logic [4:0]  gnt_c;
    logic [11:0] rom_addr_c;
    logic        rom_rden_c;
    logic [7:0]  rom_q_c;
    logic [7:0]  rdata_c;
    logic [4:0]  rvalid_c;

    int n_chk;
    int n_err;

    enemy_rom_arbiter #(.N_CH(8), .ADDR_W(12), .DATA_W(8), .ROM_LAT(2)) dut_a (
        .clk(clk), .rst(rst), .req(req_a), .addr_in(addr_a), .gnt(gnt_a),
        .rom_addr(rom_addr_a), .rom_rden(rom_rden_a), .rom_q(rom_q_a),
        .rdata(rdata_a), .rvalid(rvalid_a));

    enemy_rom_arbiter #(.N_CH(5), .ADDR_W(12), .DATA_W(8), .ROM_LAT(1)) dut_b (
        .clk(clk), .rst(rst), .req(req_b), .addr_in(addr_b), .gnt(gnt_b),
        .rom_addr(rom_addr_b), .rom_rden(rom_rden_b), .rom_q(rom_q_b),
        .rdata(rdata_b), .rvalid(rvalid_b));

    enemy_rom_arbiter #(.N_CH(5), .ADDR_W(12), .DATA_W(8), .ROM_LAT(4)) dut_c (
        .clk(clk), .rst(rst), .req(req_c), .addr_in(addr_c), .gnt(gnt_c),
        .rom_addr(rom_addr_c), .rom_rden(rom_rden_c), .rom_q(rom_q_c),
        .rdata(rdata_c), .rvalid(rvalid_c));

    // ROM models: data is valid ROM_LAT edges after the accept edge.
    logic [11:0] rom_a_d0;
    logic [11:0] rom_c_d0, rom_c_d1, rom_c_d2;

    always @(posedge clk) begin
        rom_a_d0 <= rom_addr_a;
        rom_c_d0 <= rom_addr_c;
        rom_c_d1 <= rom_c_d0;
        rom_c_d2 <= rom_c_d1;
    end

    assign rom_q_a = rom_a_d0[7:0];
    assign rom_q_b = rom_addr_b[7:0];
    assign rom_q_c = rom_c_d2[7:0];

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef ENEMY_ARB_FIXED_PRIO_EN
    localparam logic [7:0] CONT_FIRST = 8'h01;
`else
    localparam logic [7:0] CONT_FIRST = 8'h80;
`endif

    // Index of the channel granted on the n-th accept when every request
    // is held high.
    function automatic int all_req_idx(input int n, input int nch);
`ifdef ENEMY_ARB_FIXED_PRIO_EN
        return 0;
`else
        return n % nch;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int j;
        logic [7:0] rem;
        n_chk  = 0;
        n_err  = 0;
        rst    = 1'b1;
        req_a  = '0;
        req_b  = '0;
        req_c  = '0;
        addr_a = '0;
        addr_b = '0;
        addr_c = '0;
        for (int k = 0; k < 5; k++) begin
            addr_b[k*12 +: 12] = 12'h050 + 12'(k);
            addr_c[k*12 +: 12] = 12'h050 + 12'(k);
        end

        // Reset, then 20 idle cycles.
        repeat (2) tick();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_gnt",      gnt_a,      0);
            chk("idle_rden",     rom_rden_a, 0);
            chk("idle_rvalid",   rvalid_a,   0);
            chk("idle_rom_addr", rom_addr_a, 0);
        end

        // Single request from channel 3.
        addr_a[3*12 +: 12] = 12'h2A5;
        req_a = 8'h08;
        #1 chk("single_gnt", gnt_a, 8'h08);
        tick();
        req_a = 8'h00;
        chk("single_rom_addr", rom_addr_a, 12'h2A5);
        chk("single_rden",     rom_rden_a, 1);
        chk("single_rv_e1",    rvalid_a,   0);
        tick();
        chk("single_rden_off", rom_rden_a, 0);
        chk("single_rv_e2",    rvalid_a,   0);
        tick();
        chk("single_rvalid",   rvalid_a,   8'h08);
        chk("single_rdata",    rdata_a,    8'hA5);
        tick();
        chk("single_rv_drop",  rvalid_a,   0);
        chk("single_rd_hold",  rdata_a,    8'hA5);

        // Round-robin with all requests held high for 16 cycles.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 8; k++) addr_a[k*12 +: 12] = 12'h300 + 12'(k * 8'h11);
        for (int i = 0; i < 19; i++) begin
            req_a = (i < 16) ? 8'hFF : 8'h00;
            #1;
            chk("rr_gnt", gnt_a, (i < 16) ? (32'd1 << all_req_idx(i, 8)) : 32'd0);
            j = i - 3;
            if (j >= 0 && j < 16) begin
                chk("rr_rvalid", rvalid_a, 32'd1 << all_req_idx(j, 8));
                chk("rr_rdata",  rdata_a,  all_req_idx(j, 8) * 8'h11);
            end else begin
                chk("rr_rvalid_idle", rvalid_a, 0);
            end
            tick();
        end

        // Contention after wrap: move ptr to 7 by granting channel 6.
        req_a = 8'h40;
        #1 chk("cont_pre", gnt_a, 8'h40);
        tick();
        req_a = 8'h81;
        #1 chk("cont_first", gnt_a, CONT_FIRST);
        tick();
        rem   = 8'h81 & ~CONT_FIRST;
        req_a = rem;
        #1 chk("cont_second", gnt_a, rem);
        tick();
        req_a = 8'h00;
        repeat (4) tick();

        // Reset while two reads are in flight.
        addr_a[2*12 +: 12] = 12'h1C2;
        addr_a[5*12 +: 12] = 12'h0D5;
        addr_a[4*12 +: 12] = 12'h3C4;
        req_a = 8'h04;
        #1 chk("mid_gnt2", gnt_a, 8'h04);
        tick();
        req_a = 8'h20;
        #1 chk("mid_gnt5", gnt_a, 8'h20);
        tick();
        req_a = 8'h00;
        rst   = 1'b1;
        #1;
        chk("mid_rst_rden",   rom_rden_a, 0);
        chk("mid_rst_addr",   rom_addr_a, 0);
        chk("mid_rst_rvalid", rvalid_a,   0);
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("mid_no_rvalid", rvalid_a, 0);
        end
        req_a = 8'h11;
        #1 chk("mid_ptr_zero", gnt_a, 8'h01);
        req_a = 8'h10;
        #1 chk("mid_gnt4", gnt_a, 8'h10);
        tick();
        req_a = 8'h00;
        tick();
        tick();
        chk("mid_rvalid4", rvalid_a, 8'h10);
        chk("mid_rdata4",  rdata_a,  8'hC4);

        // N_CH=5 sweep: ROM_LAT=1 (return after 2 edges) and ROM_LAT=4 (after 5).
        for (int i = 0; i < 16; i++) begin
            req_b = (i < 10) ? 5'h1F : 5'h00;
            req_c = req_b;
            #1;
            chk("sw_gnt_b", gnt_b, (i < 10) ? (32'd1 << all_req_idx(i, 5)) : 32'd0);
            chk("sw_gnt_c", gnt_c, (i < 10) ? (32'd1 << all_req_idx(i, 5)) : 32'd0);
            j = i - 2;
            if (j >= 0 && j < 10) begin
                chk("sw_rvalid_b", rvalid_b, 32'd1 << all_req_idx(j, 5));
                chk("sw_rdata_b",  rdata_b,  8'h50 + all_req_idx(j, 5));
            end else begin
                chk("sw_rvalid_b_idle", rvalid_b, 0);
            end
            j = i - 5;
            if (j >= 0 && j < 10) begin
                chk("sw_rvalid_c", rvalid_c, 32'd1 << all_req_idx(j, 5));
                chk("sw_rdata_c",  rdata_c,  8'h50 + all_req_idx(j, 5));
            end else begin
                chk("sw_rvalid_c_idle", rvalid_c, 0);
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
